dec_unbinder_seq: RTL and testbench
===================================

// Module: dec_unbinder_seq
// PURPOSE
// - Decode-side inverse of the encoder binder bank: captures one bound sparse HV and streams its
//   per-feature unbound (inverse-rotated) copies, one feature per accepted beat.
// - Sits between the query/associative-memory path and the per-feature level lookup.
// - Time-multiplexed: one rotator is shared across all FEATURES_PER_CC features.
// PARAMETERS
// - HV_DIM           default 1024  hypervector width in bits
// - FEATURES_PER_CC  default 8     features unbound per capture; must be >= 1
// - SHIFTS           default hdc_pkg::SHIFTS  per-feature encoder rotate amounts, int [0:FEATURES_PER_CC-1]
// PORTS
// - clk             in   1               clock; all logic is on the rising edge
// - nrst            in   1               reset; synchronous, active-high
// - start_decoding  in   1               capture request; effective only as start_decoding && en
// - en              in   1               block enable; gates start_decoding
// - bound_hv        in   HV_DIM          bound HV; sampled only on the accepted start
// - busy            out  1               high from the accepted start until done
// - out_valid       out  1               unbound_hv/feat_idx are valid
// - out_ready       in   1               downstream accepts the current beat
// - unbound_hv      out  HV_DIM          rotr(captured HV, SHIFTS[feat_idx] % HV_DIM)
// - feat_idx        out  CW=max(1,$clog2(FEATURES_PER_CC))  feature index of the current beat
// - done            out  1               single-cycle pulse after the last beat is accepted
// BEHAVIOUR
// - Reset (nrst=1 at edge): state=IDLE, hv_q=0, cnt=0. Outputs: busy=0, out_valid=0, done=0,
//   feat_idx=0, unbound_hv=0. Reset overrides everything, including mid-stream: the stream is
//   abandoned, no done pulse, and the next start begins again at feature 0.
// - FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start_decoding&&en -> hv_q<=bound_hv, cnt<=0, go RUN. out_valid stays 0 in this cycle,
//         so the first valid beat appears one cycle after the start.
//   RUN:  out_valid=1, busy=1. Beat fires on out_valid&&out_ready.
//         On a beat with cnt<FEATURES_PER_CC-1: cnt++.
//         On a beat with cnt==FEATURES_PER_CC-1: go DONE.
//   DONE: done=1, busy=1, out_valid=0 for exactly one cycle, then go IDLE.
// - Inverse binding: the encoder rotates left by SHIFTS[i], so this block rotates right:
//   unbound_hv[b] = hv_q[(b + S) % HV_DIM], with S = SHIFTS[i] % HV_DIM.
//   S==0 is passthrough. Shifts >= HV_DIM wrap modulo HV_DIM.
// - Backpressure: while out_ready=0, unbound_hv and feat_idx hold stable. Beats are never dropped
//   or duplicated.
// - start_decoding in RUN or DONE is ignored; bound_hv is not re-sampled.
// - FEATURES_PER_CC==1: one beat, then DONE.
// - unbound_hv/feat_idx are combinational from hv_q/cnt and are driven 0 when out_valid=0.
// CONFIGURATION
// - Macro UNBIND_OVERLAP_EN.
// - Defined: adds two ports.
//   ref_hv   in   HV_DIM                     level HV compared against the current beat
//   overlap  out  $clog2(HV_DIM+1)           popcount(unbound_hv & ref_hv)
//   overlap is registered: the value for beat k is valid the cycle after beat k is accepted,
//   flagged by an added output overlap_valid (1 bit). overlap and overlap_valid reset to 0.
// - Undefined: those ports and the popcount logic do not exist; all other behaviour is identical.
// STRUCTURE
// - hdc_pkg holds HV_DIM, FEATURES_PER_CC, the SHIFTS array, an hv_t typedef, and
//   function automatic rotr_hv(hv_t, int) shared with the encoder-side rotl.
// - One sub-module, dec_unbinder_rot: combinational variable right-rotate, log-shifter of
//   $clog2(HV_DIM) stages. The FSM, counter and handshake live in the top module.
// TESTING
// Bench config: HV_DIM=16, FEATURES_PER_CC=4, SHIFTS={1,3,5,17}.
// - Basic: bound_hv=16'h0001, start, out_ready=1 -> beats idx0..3 = 16'h8000, 16'h2000,
//   16'h0800, 16'h8000 (17 wraps to 1); done pulses 1 cycle after beat 3; busy drops with done.
// - Backpressure: hold out_ready=0 for 5 cycles at idx1 -> 16'h2000/idx1 stable throughout;
//   the sequence completes without loss or repeat.
// - Start ignored: pulse start with bound_hv=16'hFFFF during RUN -> stream still derives from
//   16'h0001; with en=0 in IDLE -> no capture, busy stays 0.
// - Reset mid-stream: assert nrst at idx2 -> next cycle all outputs 0, no done; restart with
//   16'h0003 -> idx0 = 16'h8001.
// - Round-trip: random bound_hv = rotl(level_hv[i], SHIFTS[i]) across 200 iterations ->
//   unbound_hv at idx i equals level_hv[i].
// - UNBIND_OVERLAP_EN: ref_hv=16'h8000 during basic stream -> overlap 1,0,0,1 with
//   overlap_valid 1 cycle after each beat.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing definitions: default dimensions, encoder rotate table,
// HV type, decoder FSM state encoding and reference rotate helpers (encoder rotl / decoder rotr).
// Consumers: dec_unbinder_seq, dec_unbinder_rot, and the encoder-side binder bank.
package hdc_pkg;

   localparam int HV_DIM          = 1024;
   localparam int FEATURES_PER_CC = 8;

   // Per-feature rotate amounts used by the encoder binder bank.
   localparam int SHIFTS [0:FEATURES_PER_CC-1] = '{0, 1, 2, 3, 5, 8, 13, 21};

   typedef logic [HV_DIM-1:0] hv_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } unbind_state_e;

   // Encoder-side bind: rotate left by s (mod HV_DIM).
   function automatic hv_t rotl_hv(hv_t v, int s);
      hv_t r;
      int  sm;
      sm = s % HV_DIM;
      r  = '0;
      for (int b = 0; b < HV_DIM; b++) begin
         r[(b + sm) % HV_DIM] = v[b];
      end
      return r;
   endfunction

   // Decoder-side unbind: rotate right by s (mod HV_DIM).
   function automatic hv_t rotr_hv(hv_t v, int s);
      hv_t r;
      int  sm;
      sm = s % HV_DIM;
      r  = '0;
      for (int b = 0; b < HV_DIM; b++) begin
         r[b] = v[(b + sm) % HV_DIM];
      end
      return r;
   endfunction

endpackage

// File: rtl/dec_unbinder_rot.sv
// Combinational variable right-rotate, log-shifter with one stage per shamt bit.
// Ports: din (W bits), shamt (AW bits, amount already reduced mod W), dout = rotr(din, shamt).
// Stage k rotates by 2^k mod W, so non-power-of-two widths still compose to shamt mod W.
module dec_unbinder_rot
   import hdc_pkg::*;
#(
   parameter int W  = 1024,
   parameter int AW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  din,
   input  logic [AW-1:0] shamt,
   output logic [W-1:0]  dout
);

   logic [W-1:0] stage_v;
   logic [W-1:0] stage_t;
   int           stage_r;

   always_comb begin
      stage_v = din;
      stage_t = '0;
      stage_r = 0;
      for (int k = 0; k < AW; k++) begin
         stage_r = (1 << k) % W;
         for (int b = 0; b < W; b++) begin
            stage_t[b] = stage_v[(b + stage_r) % W];
         end
         if (shamt[k]) begin
            stage_v = stage_t;
         end
      end
      dout = stage_v;
   end

endmodule

// File: rtl/dec_unbinder_seq.sv
// Captures one bound sparse HV and streams its per-feature unbound (right-rotated) copies,
// one feature per accepted beat, sharing a single rotator. First beat 1 cycle after start;
// beats hold stable under out_ready=0. Optional macro UNBIND_OVERLAP_EN adds ref_hv input and
// registered overlap/overlap_valid (popcount of unbound_hv & ref_hv, valid the cycle after a beat).
// Ports: clk, nrst (sync, active-high), start_decoding/en/bound_hv in; busy, out_valid, out_ready,
// unbound_hv, feat_idx, done.
module dec_unbinder_seq
   import hdc_pkg::*;
#(
   parameter int HV_DIM          = hdc_pkg::HV_DIM,
   parameter int FEATURES_PER_CC = hdc_pkg::FEATURES_PER_CC,
   parameter int SHIFTS [0:FEATURES_PER_CC-1] = hdc_pkg::SHIFTS,
   parameter int CW = (FEATURES_PER_CC > 1) ? $clog2(FEATURES_PER_CC) : 1,
   parameter int OW = $clog2(HV_DIM + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start_decoding,
   input  logic              en,
   input  logic [HV_DIM-1:0] bound_hv,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [HV_DIM-1:0] unbound_hv,
   output logic [CW-1:0]     feat_idx,
   output logic              done
`ifdef UNBIND_OVERLAP_EN
   ,
   input  logic [HV_DIM-1:0] ref_hv,
   output logic [OW-1:0]     overlap,
   output logic              overlap_valid
`endif
);

   localparam int AW = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(FEATURES_PER_CC - 1);

   unbind_state_e     state_q, state_d;
   logic [HV_DIM-1:0] hv_q, hv_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              out_valid_q, out_valid_d;
   logic              done_q, done_d;

   logic              beat;
   logic [AW-1:0]     shamt;
   logic [HV_DIM-1:0] rot_hv;

   // Next-state logic; status outputs are decoded from the next state so they come out of flops.
   always_comb begin
      state_d = state_q;
      hv_d    = hv_q;
      cnt_d   = cnt_q;
      beat    = out_valid_q && out_ready;
      case (state_q)
         ST_IDLE: begin
            if (start_decoding && en) begin
               hv_d    = bound_hv;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (beat) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d      = (state_d != ST_IDLE);
      out_valid_d = (state_d == ST_RUN);
      done_d      = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q     <= ST_IDLE;
         hv_q        <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hv_q        <= hv_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   // Per-feature rotate amount, reduced mod HV_DIM so oversize encoder shifts wrap.
   always_comb begin
      shamt = '0;
      for (int i = 0; i < FEATURES_PER_CC; i++) begin
         if (cnt_q == CW'(i)) begin
            shamt = AW'(SHIFTS[i] % HV_DIM);
         end
      end
   end

   dec_unbinder_rot #(
      .W  (HV_DIM),
      .AW (AW)
   ) u_rot (
      .din   (hv_q),
      .shamt (shamt),
      .dout  (rot_hv)
   );

   assign busy       = busy_q;
   assign out_valid  = out_valid_q;
   assign done       = done_q;
   assign unbound_hv = out_valid_q ? rot_hv : '0;
   assign feat_idx   = out_valid_q ? cnt_q  : '0;

`ifdef UNBIND_OVERLAP_EN
   logic [OW-1:0] overlap_q, overlap_d;
   logic          overlap_valid_q;

   always_comb begin
      overlap_d = '0;
      for (int b = 0; b < HV_DIM; b++) begin
         overlap_d = overlap_d + OW'(unbound_hv[b] & ref_hv[b]);
      end
   end

   // Overlap is latched only on accepted beats so it always belongs to the last beat taken.
   always_ff @(posedge clk) begin
      if (nrst) begin
         overlap_q       <= '0;
         overlap_valid_q <= 1'b0;
      end else begin
         overlap_valid_q <= beat;
         if (beat) begin
            overlap_q <= overlap_d;
         end
      end
   end

   assign overlap       = overlap_q;
   assign overlap_valid = overlap_valid_q;
`endif

endmodule

// File: tb/tb_dec_unbinder_seq.sv
module tb_dec_unbinder_seq;

   localparam int HV_DIM = 16;
   localparam int FPC    = 4;
   localparam int CW     = 2;
   localparam int OW     = 5;
   localparam int SH [0:FPC-1] = '{1, 3, 5, 17};

   logic              clk = 1'b0;
   logic              nrst;
   logic              start_decoding;
   logic              en;
   logic [HV_DIM-1:0] bound_hv;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [HV_DIM-1:0] unbound_hv;
   logic [CW-1:0]     feat_idx;
   logic              done;
`ifdef UNBIND_OVERLAP_EN
   logic [HV_DIM-1:0] ref_hv;
   logic [OW-1:0]     overlap;
   logic              overlap_valid;
`endif

   always #5 clk = ~clk;

   dec_unbinder_seq #(
      .HV_DIM          (HV_DIM),
      .FEATURES_PER_CC (FPC),
      .SHIFTS          (SH)
   ) dut (
      .clk            (clk),
      .nrst           (nrst),
      .start_decoding (start_decoding),
      .en             (en),
      .bound_hv       (bound_hv),
      .busy           (busy),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .unbound_hv     (unbound_hv),
      .feat_idx       (feat_idx),
      .done           (done)
`ifdef UNBIND_OVERLAP_EN
      ,
      .ref_hv         (ref_hv),
      .overlap        (overlap),
      .overlap_valid  (overlap_valid)
`endif
   );

   typedef struct packed {
      logic [HV_DIM-1:0] hv;
      logic [CW-1:0]     idx;
   } beat_t;

   beat_t sb[$];
   int    checks = 0;
   int    errors = 0;
`ifdef UNBIND_OVERLAP_EN
   logic [OW-1:0] ov_q[$];
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference rotates written with shifts, independent of the bit-index form in the design.
   function automatic logic [HV_DIM-1:0] rotl_m(input logic [HV_DIM-1:0] v, input int s);
      int sm;
      sm = s % HV_DIM;
      if (sm == 0) return v;
      return (v << sm) | (v >> (HV_DIM - sm));
   endfunction

   function automatic logic [HV_DIM-1:0] rotr_m(input logic [HV_DIM-1:0] v, input int s);
      int sm;
      sm = s % HV_DIM;
      if (sm == 0) return v;
      return (v >> sm) | (v << (HV_DIM - sm));
   endfunction

   // Scoreboard monitor: every accepted beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (!nrst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got idx %0d hv %0h with nothing expected", feat_idx, unbound_hv);
         end else begin
            beat_t e;
            e = sb.pop_front();
            check("beat_hv", 32'(unbound_hv), 32'(e.hv));
            check("beat_idx", 32'(feat_idx), 32'(e.idx));
         end
      end
`ifdef UNBIND_OVERLAP_EN
      if (!nrst && overlap_valid) begin
         if (ov_q.size() != 0) check("overlap", 32'(overlap), 32'(ov_q.pop_front()));
         else check("overlap_zero_ref", 32'(overlap), 32'd0);
      end
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_stream(input logic [HV_DIM-1:0] hv);
      for (int j = 0; j < FPC; j++) begin
         beat_t e;
         e.hv  = rotr_m(hv, SH[j]);
         e.idx = CW'(j);
         sb.push_back(e);
      end
   endtask

   task automatic start_capture(input logic [HV_DIM-1:0] hv);
      bound_hv       = hv;
      start_decoding = 1'b1;
      en             = 1'b1;
      tick();
      start_decoding = 1'b0;
   endtask

   // Waits for done with a cycle budget; optionally randomises out_ready each cycle.
   task automatic wait_done(input string name, input bit rnd_ready, output int n);
      n = 0;
      while (!done && n < 100) begin
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      if (!done) check({name, "_done_timeout"}, 32'(done), 32'd1);
      out_ready = 1'b1;
   endtask

   initial begin
      int n;
      nrst           = 1'b1;
      start_decoding = 1'b0;
      en             = 1'b1;
      bound_hv       = '0;
      out_ready      = 1'b1;
`ifdef UNBIND_OVERLAP_EN
      ref_hv         = '0;
`endif
      tick();
      tick();
      nrst = 1'b0;

      // Reset state
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_idx", 32'(feat_idx), 32'd0);
      check("rst_hv", 32'(unbound_hv), 32'd0);

      // Basic stream: hand-computed beats for 16'h0001
      begin
         beat_t e;
         e.hv = 16'h8000; e.idx = 2'd0; sb.push_back(e);
         e.hv = 16'h2000; e.idx = 2'd1; sb.push_back(e);
         e.hv = 16'h0800; e.idx = 2'd2; sb.push_back(e);
         e.hv = 16'h8000; e.idx = 2'd3; sb.push_back(e);
      end
`ifdef UNBIND_OVERLAP_EN
      ref_hv = 16'h8000;
      ov_q.push_back(OW'(1));
      ov_q.push_back(OW'(0));
      ov_q.push_back(OW'(0));
      ov_q.push_back(OW'(1));
`endif
      start_capture(16'h0001);
      check("basic_busy", 32'(busy), 32'd1);
      check("basic_valid", 32'(out_valid), 32'd1);
      wait_done("basic", 1'b0, n);
      check("basic_done_latency", 32'(n), 32'd4);
      check("basic_done_busy", 32'(busy), 32'd1);
      check("basic_done_valid", 32'(out_valid), 32'd0);
      tick();
`ifdef UNBIND_OVERLAP_EN
      ref_hv = '0;
`endif
      check("basic_done_pulse", 32'(done), 32'd0);
      check("basic_idle_busy", 32'(busy), 32'd0);
      check("basic_sb_empty", 32'(sb.size()), 32'd0);

      // Backpressure at idx1 for 5 cycles
      push_stream(16'h0001);
      start_capture(16'h0001);
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_idx", 32'(feat_idx), 32'd1);
         check("bp_hv", 32'(unbound_hv), 32'h2000);
         tick();
      end
      out_ready = 1'b1;
      wait_done("bp", 1'b0, n);
      tick();
      check("bp_sb_empty", 32'(sb.size()), 32'd0);

      // Start during RUN is ignored; stream still derived from 16'h0001
      push_stream(16'h0001);
      start_capture(16'h0001);
      bound_hv       = 16'hFFFF;
      start_decoding = 1'b1;
      tick();
      start_decoding = 1'b0;
      wait_done("ign", 1'b0, n);
      tick();
      check("ign_sb_empty", 32'(sb.size()), 32'd0);

      // en=0 in IDLE: no capture
      en             = 1'b0;
      start_decoding = 1'b1;
      tick();
      check("en0_busy", 32'(busy), 32'd0);
      check("en0_valid", 32'(out_valid), 32'd0);
      start_decoding = 1'b0;
      tick();
      check("en0_busy2", 32'(busy), 32'd0);
      en = 1'b1;

      // Reset mid-stream at idx2
      push_stream(16'h0001);
      start_capture(16'h0001);
      tick();
      tick();
      check("mid_idx_before_rst", 32'(feat_idx), 32'd2);
      out_ready = 1'b0;
      nrst      = 1'b1;
      tick();
      nrst = 1'b0;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_hv", 32'(unbound_hv), 32'd0);
      check("mid_rst_idx", 32'(feat_idx), 32'd0);
      check("mid_abandoned", 32'(sb.size()), 32'd2);
      sb.delete();
      tick();
      check("mid_no_done", 32'(done), 32'd0);
      out_ready = 1'b1;
      begin
         beat_t e;
         e.hv = 16'h8001; e.idx = 2'd0; sb.push_back(e);
         e.hv = 16'h6000; e.idx = 2'd1; sb.push_back(e);
         e.hv = 16'h1800; e.idx = 2'd2; sb.push_back(e);
         e.hv = 16'h8001; e.idx = 2'd3; sb.push_back(e);
      end
      start_capture(16'h0003);
      check("restart_idx0", 32'(feat_idx), 32'd0);
      check("restart_hv0", 32'(unbound_hv), 32'h8001);
      wait_done("restart", 1'b0, n);
      tick();

      // Round-trip: bound = rotl(level, S_i) must unbind to level at idx i
      for (int it = 0; it < 200; it++) begin
         logic [HV_DIM-1:0] level;
         logic [HV_DIM-1:0] bnd;
         int                fi;
         fi    = it % FPC;
         level = HV_DIM'($urandom());
         bnd   = rotl_m(level, SH[fi]);
         for (int j = 0; j < FPC; j++) begin
            beat_t e;
            e.hv  = (j == fi) ? level : rotr_m(bnd, SH[j]);
            e.idx = CW'(j);
            sb.push_back(e);
         end
         start_capture(bnd);
         wait_done("rt", 1'b1, n);
         tick();
      end
      check("rt_sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
